// File: rtl/deserializer_if.sv
// Beat-in / word-out handshake bundle for the deserializer.
// state_dbg mirrors the assembly FSM (0 = COLLECT, 1 = STALL).
interface deserializer_if #(
    parameter int depth = 1,
    parameter int width = 1
);
    logic [width-1:0]       serial_in;
    logic                   serial_valid;
    logic                   serial_ready;
    logic [depth*width-1:0] parallel_out;
    logic                   parallel_valid;
    logic                   parallel_ready;
    logic                   busy;
    logic                   state_dbg;

    // Both ports are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; ready never depends on valid, and a
    // producer holds valid and data steady until the transfer happens.
    modport master (
        output serial_in, serial_valid, parallel_ready,
        input  serial_ready, parallel_out, parallel_valid, busy, state_dbg
    );
    modport slave (
        input  serial_in, serial_valid, parallel_ready,
        output serial_ready, parallel_out, parallel_valid, busy, state_dbg
    );
endinterface

// File: rtl/deserializer.sv
// Gathers depth beats of width bits (first beat = LSB slice) into one word, double-buffered.
// Optional synchronous partial-word flush: define DESERIALIZER_FLUSH_EN.
module deserializer #(
    parameter int depth = 1,
    parameter int width = 1
) (
    input  logic clock,
    input  logic reset,
`ifdef DESERIALIZER_FLUSH_EN
    input  logic flush,
`endif
    deserializer_if.slave bus
);
    localparam int CW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [CW-1:0] LAST = CW'(depth - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [depth*width-1:0] r_asm;
    logic [depth*width-1:0] r_out;
    logic                   r_out_valid;

    logic                   w_beat_acc;
    logic                   w_out_hs;
    logic                   w_last;
    logic                   w_flush;
    logic [depth*width-1:0] w_word;

`ifdef DESERIALIZER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign bus.serial_ready   = (r_state == COLLECT);
    assign bus.parallel_out   = r_out;
    assign bus.parallel_valid = r_out_valid;
    assign bus.busy           = (r_cnt != '0) || (r_state == STALL);
    assign bus.state_dbg      = r_state;

    assign w_beat_acc = bus.serial_valid && (r_state == COLLECT);
    assign w_out_hs   = r_out_valid && bus.parallel_ready;
    assign w_last     = (r_cnt == LAST);

    // Completed word as it would look with the incoming beat in the top slice.
    always_comb begin
        w_word = r_asm;
        w_word[(depth-1)*width +: width] = bus.serial_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_out_hs)
                r_out_valid <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_beat_acc && !w_flush) begin
                        if (!w_last) begin
                            r_asm[int'(r_cnt)*width +: width] <= bus.serial_in;
                            r_cnt <= r_cnt + 1'b1;
                        end else if (!r_out_valid || w_out_hs) begin
                            r_out       <= w_word;
                            r_out_valid <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_asm[(depth-1)*width +: width] <= bus.serial_in;
                            r_state <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (w_out_hs) begin
                        if (!w_flush) begin
                            r_out       <= r_asm;
                            r_out_valid <= 1'b1;
                        end
                        r_state <= COLLECT;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= COLLECT;
            endcase
            // Flush drops the partial/held assembly word but leaves the output slot alone.
            if (w_flush) begin
                r_cnt   <= '0;
                r_state <= COLLECT;
            end
        end
    end
endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed vector tables, reset/flush sequences and a randomized
// run against a beat-queue reference model (depth=4,width=8 plus a depth=1,width=4 instance).
module tb_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deserializer_if #(.depth(4), .width(8)) if4 ();
    deserializer_if #(.depth(1), .width(4)) if1 ();

`ifdef DESERIALIZER_FLUSH_EN
    logic flush4 = 1'b0;
    logic flush1 = 1'b0;
`endif

    deserializer #(.depth(4), .width(8)) u_dut4 (
        .clock (clk),
        .reset (rst),
`ifdef DESERIALIZER_FLUSH_EN
        .flush (flush4),
`endif
        .bus   (if4)
    );

    deserializer #(.depth(1), .width(4)) u_dut1 (
        .clock (clk),
        .reset (rst),
`ifdef DESERIALIZER_FLUSH_EN
        .flush (flush1),
`endif
        .bus   (if1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic        sv;
        logic [7:0]  sin;
        logic        pr;
        logic        exp_pv;
        logic [31:0] exp_po;
        logic        exp_sr;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic sv, logic [7:0] sin, logic pr, logic pv,
                                logic [31:0] po, logic sr, logic busy);
        vec_t v;
        v.sv = sv; v.sin = sin; v.pr = pr; v.exp_pv = pv;
        v.exp_po = po; v.exp_sr = sr; v.exp_busy = busy;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic sv, input logic [7:0] sin, input logic pr);
        if4.serial_valid   = sv;
        if4.serial_in      = sin;
        if4.parallel_ready = pr;
    endtask

    task automatic check4(input string tag, input logic pv, input logic [31:0] po,
                          input logic sr, input logic busy);
        check({tag, " pvalid"}, 32'(if4.parallel_valid), 32'(pv));
        if (pv) check({tag, " pout"}, if4.parallel_out, po);
        check({tag, " sready"}, 32'(if4.serial_ready), 32'(sr));
        check({tag, " busy"}, 32'(if4.busy), 32'(busy));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " d4 pvalid"}, 32'(if4.parallel_valid), 32'd0);
        check({tag, " d4 pout"}, if4.parallel_out, 32'd0);
        check({tag, " d4 sready"}, 32'(if4.serial_ready), 32'd1);
        check({tag, " d4 busy"}, 32'(if4.busy), 32'd0);
        check({tag, " d1 pvalid"}, 32'(if1.parallel_valid), 32'd0);
        check({tag, " d1 sready"}, 32'(if1.serial_ready), 32'd1);
    endtask

    // Reference model: accepted beats queue up until four make a word; words wait in exp_q.
    logic [7:0]  part_q[$];
    logic [31:0] exp_q[$];

    initial begin
        drive4(1'b0, 8'h00, 1'b0);
        if1.serial_valid = 1'b0; if1.serial_in = 4'h0; if1.parallel_ready = 1'b0;
        #2;
        check_reset_vals("reset_at_start");
        tick();
        rst = 1'b0;

        // Single word with ready high, then backpressure through stall and release.
        vecs.push_back(mk(1, 8'h11, 1, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 8'h22, 1, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 8'h33, 1, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 8'h44, 1, 1, 32'h44332211, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 8'h01, 0, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 8'h02, 0, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 8'h03, 0, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 8'h04, 0, 1, 32'h04030201, 1, 0));
        vecs.push_back(mk(1, 8'h05, 0, 1, 32'h04030201, 1, 1));
        vecs.push_back(mk(1, 8'h06, 0, 1, 32'h04030201, 1, 1));
        vecs.push_back(mk(1, 8'h07, 0, 1, 32'h04030201, 1, 1));
        vecs.push_back(mk(1, 8'h08, 0, 1, 32'h04030201, 0, 1));
        vecs.push_back(mk(1, 8'h09, 0, 1, 32'h04030201, 0, 1));
        vecs.push_back(mk(1, 8'h09, 0, 1, 32'h04030201, 0, 1));
        vecs.push_back(mk(1, 8'h09, 0, 1, 32'h04030201, 0, 1));
        vecs.push_back(mk(1, 8'h09, 1, 1, 32'h08070605, 1, 0));
        vecs.push_back(mk(1, 8'h09, 1, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 8'h0A, 1, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 8'h0B, 1, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 8'h0C, 1, 1, 32'h0C0B0A09, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 32'h0, 1, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            drive4(vecs[i].sv, vecs[i].sin, vecs[i].pr);
            tick();
            check4($sformatf("vec%0d", i), vecs[i].exp_pv, vecs[i].exp_po,
                   vecs[i].exp_sr, vecs[i].exp_busy);
        end

        // Randomized run: ~75% beat offers, parallel_ready toggling every cycle.
        begin
            logic pr_t;
            pr_t = 1'b0;
            for (int c = 0; c < 400; c++) begin
                logic       sv;
                logic [7:0] b;
                logic       acc;
                logic       hs;
                sv   = ($urandom_range(0, 3) != 0);
                b    = 8'($urandom);
                pr_t = ~pr_t;
                drive4(sv, b, pr_t);
                acc = sv && (exp_q.size() < 2);
                hs  = (exp_q.size() >= 1) && pr_t;
                tick();
                if (hs) void'(exp_q.pop_front());
                if (acc) begin
                    part_q.push_back(b);
                    if (part_q.size() == 4) begin
                        exp_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
                        part_q.delete();
                    end
                end
                check4("rand", exp_q.size() >= 1, (exp_q.size() >= 1) ? exp_q[0] : 32'h0,
                       exp_q.size() < 2, (part_q.size() != 0) || (exp_q.size() == 2));
            end
            drive4(1'b0, 8'h00, 1'b1);
            while (exp_q.size() != 0) begin
                tick();
                void'(exp_q.pop_front());
            end
            tick();
            while (part_q.size() != 0) void'(part_q.pop_front());
        end

        // Reset while stalled with two words held.
        for (int i = 1; i <= 8; i++) begin
            drive4(1'b1, 8'(i), 1'b0);
            tick();
        end
        check("stall before reset sready", 32'(if4.serial_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_vals("reset_in_stall");
        tick();
        rst = 1'b0;

        // Reset mid-word: 0xAA, 0xBB must be discarded.
        drive4(1'b1, 8'hAA, 1'b1); tick();
        drive4(1'b1, 8'hBB, 1'b1); tick();
        drive4(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_vals("reset_mid_word");
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive4(1'b1, 8'(i), 1'b1);
            tick();
        end
        check4("after reset word", 1'b1, 32'h04030201, 1'b1, 1'b0);
        drive4(1'b0, 8'h00, 1'b1);
        tick();

        // depth=1: every beat is a word, back to back.
        begin
            logic [3:0] beats [3];
            beats[0] = 4'h3; beats[1] = 4'h5; beats[2] = 4'h9;
            if1.parallel_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if1.serial_valid = 1'b1;
                if1.serial_in    = beats[i];
                tick();
                check($sformatf("d1 pvalid%0d", i), 32'(if1.parallel_valid), 32'd1);
                check($sformatf("d1 pout%0d", i), 32'(if1.parallel_out), 32'(beats[i]));
                check($sformatf("d1 busy%0d", i), 32'(if1.busy), 32'd0);
            end
            if1.serial_valid = 1'b0;
            tick();
            check("d1 idle pvalid", 32'(if1.parallel_valid), 32'd0);
        end

`ifdef DESERIALIZER_FLUSH_EN
        drive4(1'b1, 8'h11, 1'b1); tick();
        drive4(1'b1, 8'h22, 1'b1); tick();
        check("flush pre busy", 32'(if4.busy), 32'd1);
        drive4(1'b1, 8'h33, 1'b1);
        flush4 = 1'b1;
        tick();
        flush4 = 1'b0;
        check4("flush cycle", 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            drive4(1'b1, 8'(i), 1'b1);
            tick();
            check4($sformatf("flush word beat%0d", i), i == 4, 32'h04030201, 1'b1, i != 4);
        end
        drive4(1'b0, 8'h00, 1'b1);
        tick();
        check("flush idle pvalid", 32'(if4.parallel_valid), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/deserializer.md
# deserializer

Collects a stream of `width`-bit beats and assembles every `depth` beats into one `depth*width`-bit word delivered on a valid/ready parallel port. It sits directly downstream of the parallel-load `shifter` and undoes that stage's serialisation: the shifter's `serial_out` drives `serial_in` here, so the first beat received is the least-significant slice. A two-stage buffer lets the next word be assembled while the previous word waits for the consumer.

## Interface
- `depth`, default 1: beats per word, ≥1.
- `width`, default 1: bits per beat, ≥1.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `serial_in`  in  width  incoming beat.
- `serial_valid`  in  1  `serial_in` is valid this cycle.
- `serial_ready`  out  1  block accepts a beat this cycle.
- `parallel_out`  out  depth*width  assembled word; beat k occupies bits [(k+1)*width-1 : k*width].
- `parallel_valid`  out  1  `parallel_out` holds a word.
- `parallel_ready`  in  1  consumer takes the word this cycle.
- `busy`  out  1  a partial or stalled word is in the assembly stage.
- `flush`  in  1  present only with `DESERIALIZER_FLUSH_EN`; see Configuration.

## Operation
- State:
  - assembly register `asm`, `depth*width` bits;
  - beat counter `cnt`, 0..depth-1, width max(1, clog2(depth));
  - flag `asm_full`;
  - output register `out`;
  - `out_valid`.
- FSM:
  - COLLECT (`asm_full`=0).
  - STALL (`asm_full`=1).
- Beat accept: `serial_valid && serial_ready`. Output handshake: `parallel_valid && parallel_ready`.
- `serial_ready` = !`asm_full`. This is combinational from state only; it never depends on `serial_valid`.
- COLLECT, beat accepted, `cnt` < depth-1:
  - write the beat to slice `cnt` of `asm`;
  - `cnt` += 1.
- COLLECT, beat accepted, `cnt` == depth-1 (word complete):
  - Output slot free (`out_valid`==0, or output handshake in the same cycle): `out` ← {beat, `asm` lower slices}; `out_valid` ← 1; `cnt` ← 0.
  - Otherwise: write the beat to slice depth-1 of `asm`; go to STALL.
- STALL:
  - On output handshake: `out` ← `asm`; `out_valid` stays 1; `asm_full` ← 0; `cnt` ← 0; return to COLLECT.
  - No beat is accepted while in STALL.
- Output handshake with no replacement word: `out_valid` ← 0.
- `depth`=1: every accepted beat completes a word.
- `busy` = (`cnt` != 0) || `asm_full`.
- Slices of `asm` not yet written in the current word hold stale data. Only complete words reach `out`.
- `parallel_out` = `out`. Its contents are don't-care while `parallel_valid`=0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `cnt`=0, `asm_full`=0, `out_valid`=0;
  - `asm`=0, `out`=0;
  - outputs: `serial_ready`=1, `parallel_valid`=0, `busy`=0, `parallel_out`=0.
- Reset mid-word or mid-stall discards all partial and held data. The first beat after reset deasserts is slice 0.
- Latency: last beat of a word accepted on edge N → `parallel_valid`=1 with that word after edge N.
- Throughput: one beat per cycle sustained while `parallel_ready` stays high. No bubble between words.
- Backpressure: with `parallel_ready` low, the block absorbs one held word plus `depth` beats. `serial_ready` drops after the edge that completes the second word.
- STALL release: output handshake on edge M → second word on `parallel_out` and `serial_ready`=1 after edge M.
- `parallel_out` and `parallel_valid` are stable while `parallel_valid`=1 and `parallel_ready`=0.

## Configuration
- `DESERIALIZER_FLUSH_EN` defined:
  - adds input `flush`, synchronous, active-high;
  - on an edge with `flush`=1: `cnt` ← 0, `asm_full` ← 0, state ← COLLECT;
  - a beat accepted in the same cycle is discarded;
  - `out`/`out_valid` are unaffected, and an output handshake in the same cycle completes normally.
- Not defined: no `flush` port; the partial-word state changes only by beats and reset.

## Test plan
- depth=4, width=8; beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `parallel_ready`=1 → `parallel_out`=0x44332211, `parallel_valid` high for exactly 1 cycle, one cycle after the 0x44 beat.
- depth=4, width=8; `parallel_ready`=0; offer 12 beats 0x01..0x0C → `serial_ready` falls after 8 accepted, `parallel_out`=0x04030201 held. Raise `parallel_ready` → then 0x08070605, then 0x0C0B0A09 after 4 more beats.
- depth=4, width=8; continuous random beats with `parallel_ready` toggling every cycle → every word equals the model, no beat is lost or duplicated, and `parallel_out` is stable while stalled.
- depth=4, width=8; assert `reset` after 2 beats (0xAA, 0xBB), then send 0x01..0x04 → first word is 0x04030201; all outputs read reset values during reset.
- depth=1, width=4; beats 0x3, 0x5, 0x9 → three words 0x3, 0x5, 0x9 on consecutive cycles.
- `DESERIALIZER_FLUSH_EN`, depth=4, width=8; beats 0x11, 0x22, pulse `flush` with 0x33, then 0x01..0x04 → only word 0x04030201 is produced.
